// File: rtl/color_judge_pkg.sv
// Shared types, widths and the platform slot-extract helper for the colour judge.
package color_judge_pkg;

    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned NUM_PLATS = 4;
    localparam int unsigned PLATS_W   = COLOR_W * NUM_PLATS;
    localparam int unsigned SLOT_W    = $clog2(NUM_PLATS);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_LAND,
        JUDGE,
        OVER
    } state_t;

    // Colour of platform slot k, held in bits [3k+2:3k].
    function automatic logic [COLOR_W-1:0] slot_color(
        input logic [PLATS_W-1:0] plats,
        input logic [SLOT_W-1:0]  slot
    );
        logic [COLOR_W-1:0] c;
        c = '0;
        for (int unsigned k = 0; k < NUM_PLATS; k++) begin
            if (slot == SLOT_W'(k)) begin
                c = plats[k*COLOR_W +: COLOR_W];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/color_match_judge_slot_match.sv
// Combinational per-slot colour equality plus an any-slot flag.
module color_slot_match
    import color_judge_pkg::*;
(
    input  logic [COLOR_W-1:0]   color,
    input  logic [PLATS_W-1:0]   plats,
    output logic [NUM_PLATS-1:0] match_c,
    output logic                 any_match_c
);

    always_comb begin
        match_c = '0;
        for (int unsigned k = 0; k < NUM_PLATS; k++) begin
            match_c[k] = (slot_color(plats, SLOT_W'(k)) == color);
        end
    end

    assign any_match_c = |match_c;

endmodule

// File: rtl/color_match_judge.sv
// Round controller: latches colours (guaranteeing a reachable ball colour), waits for
// a landing or timeout, and keeps score, lives and game-over.
module color_match_judge
    import color_judge_pkg::*;
#(
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned TO_W           = 26,
    parameter int unsigned RETRY_MAX      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [COLOR_W-1:0] new_color_ball,
    input  logic [PLATS_W-1:0] new_color_plats,
    input  logic               round_start,
    input  logic               land_valid,
    input  logic [SLOT_W-1:0]  land_pos,
    output logic [COLOR_W-1:0] ball_color,
    output logic [PLATS_W-1:0] plat_colors,
    output logic               colors_valid,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic               busy
);

    localparam int unsigned        RETRY_W    = $clog2(RETRY_MAX) + 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t               state;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [SLOT_W-1:0]    pos;

    logic [COLOR_W-1:0]   color_sel_c;
    logic [PLATS_W-1:0]   plats_sel_c;
    logic [NUM_PLATS-1:0] match_c;
    logic                 any_match_c;
    logic [1:0]           lives_dec_c;
    logic                 last_life_c;

    // One matcher serves both ARM (live inputs) and JUDGE (latched colours).
    assign color_sel_c = (state == JUDGE) ? ball_color  : new_color_ball;
    assign plats_sel_c = (state == JUDGE) ? plat_colors : new_color_plats;

    color_slot_match u_match (
        .color       (color_sel_c),
        .plats       (plats_sel_c),
        .match_c     (match_c),
        .any_match_c (any_match_c)
    );

    assign lives_dec_c = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
    assign last_life_c = (lives <= 2'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            ball_color   <= '0;
            plat_colors  <= '0;
            colors_valid <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            score        <= '0;
            lives        <= 2'(LIVES_INIT);
            game_over    <= 1'b0;
            busy         <= 1'b0;
            retry_cnt    <= '0;
            to_cnt       <= '0;
            pos          <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (round_start) begin
                        state     <= ARM;
                        busy      <= 1'b1;
                        retry_cnt <= '0;
                    end
                end
                ARM: begin
                    ball_color  <= new_color_ball;
                    plat_colors <= new_color_plats;
                    retry_cnt   <= retry_cnt + RETRY_W'(1);
                    if (any_match_c) begin
                        state        <= WAIT_LAND;
                        colors_valid <= 1'b1;
                        to_cnt       <= '0;
                    end else if (retry_cnt == RETRY_LAST) begin
                        // Out of retries: force the ball colour onto slot 0.
                        plat_colors  <= {new_color_plats[PLATS_W-1:COLOR_W], new_color_ball};
                        state        <= WAIT_LAND;
                        colors_valid <= 1'b1;
                        to_cnt       <= '0;
                    end
                end
                WAIT_LAND: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (land_valid) begin
                        pos   <= land_pos;
                        state <= JUDGE;
                    end else if (to_cnt == TO_LAST) begin
                        miss         <= 1'b1;
                        lives        <= lives_dec_c;
                        colors_valid <= 1'b0;
                        busy         <= 1'b0;
                        game_over    <= last_life_c;
                        state        <= last_life_c ? OVER : IDLE;
                    end
                end
                JUDGE: begin
                    colors_valid <= 1'b0;
                    busy         <= 1'b0;
                    if (match_c[pos]) begin
                        hit   <= 1'b1;
                        state <= IDLE;
                        if (score != SCORE_MAX) begin
                            score <= score + SCORE_W'(1);
                        end
                    end else begin
                        miss      <= 1'b1;
                        lives     <= lives_dec_c;
                        game_over <= last_life_c;
                        state     <= last_life_c ? OVER : IDLE;
                    end
                end
                OVER: begin
                    game_over <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_match_judge.sv
// Randomised round-level bench for color_match_judge against a rule-based game model.
module tb_color_match_judge;

    localparam int unsigned TB_TO        = 10;
    localparam int unsigned TB_RETRY     = 4;
    localparam int unsigned TB_SCORE_MAX = 3;

    logic        clk;
    logic        resetn;
    logic [2:0]  new_color_ball;
    logic [11:0] new_color_plats;
    logic        round_start;
    logic        land_valid;
    logic [1:0]  land_pos;
    logic [2:0]  ball_color;
    logic [11:0] plat_colors;
    logic        colors_valid;
    logic        hit;
    logic        miss;
    logic [1:0]  score;
    logic [1:0]  lives;
    logic        game_over;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    int m_score;
    int m_lives;
    bit m_over;

    color_match_judge #(
        .SCORE_W        (2),
        .LIVES_INIT     (3),
        .TIMEOUT_CYCLES (TB_TO),
        .TO_W           (4),
        .RETRY_MAX      (TB_RETRY)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .new_color_ball  (new_color_ball),
        .new_color_plats (new_color_plats),
        .round_start     (round_start),
        .land_valid      (land_valid),
        .land_pos        (land_pos),
        .ball_color      (ball_color),
        .plat_colors     (plat_colors),
        .colors_valid    (colors_valid),
        .hit             (hit),
        .miss            (miss),
        .score           (score),
        .lives           (lives),
        .game_over       (game_over),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] slot_of(input logic [11:0] p, input int k);
        return 3'(p >> (3 * k));
    endfunction

    function automatic bit color_in(input logic [2:0] b, input logic [11:0] p);
        for (int k = 0; k < 4; k++) begin
            if (slot_of(p, k) == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_score = 0;
        m_lives = 3;
        m_over  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_score"}, 32'(score), 32'(m_score));
        check_eq({tag, "_lives"}, 32'(lives), 32'(m_lives));
        check_eq({tag, "_over"},  32'(game_over), 32'(m_over));
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_hit"},   32'(hit), 0);
        check_eq({tag, "_miss"},  32'(miss), 0);
    endtask

    task automatic do_reset();
        resetn          = 1'b0;
        round_start     = 1'b0;
        land_valid      = 1'b0;
        land_pos        = 2'd0;
        new_color_ball  = 3'($urandom);
        new_color_plats = 12'($urandom);
        tick();
        tick();
        resetn = 1'b1;
        model_reset();
    endtask

    // ball_in/plats_in < 0 -> random; pos_in: >=0 fixed, -1 random, -2 matching, -3 mismatching
    task automatic do_round(input int ball_in, input int plats_in, input bit nomatch,
                            input bit to_mode, input int delay, input int pos_in);
        logic [2:0]  b;
        logic [11:0] p;
        logic [2:0]  exp_b;
        logic [11:0] exp_p;
        bit          found;
        bit          exp_hit;
        int          lp;
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        check_eq("arm_entry_busy", 32'(busy), 1);
        found = 1'b0;
        exp_b = '0;
        exp_p = '0;
        for (int i = 0; i < int'(TB_RETRY) && !found; i++) begin
            if (ball_in >= 0) begin
                b = 3'(ball_in);
                p = 12'(plats_in);
            end else begin
                b = 3'($urandom);
                p = 12'($urandom);
                if (nomatch) begin
                    for (int k = 0; k < 4; k++) p[k*3 +: 3] = b ^ 3'($urandom_range(1, 7));
                end
            end
            new_color_ball  = b;
            new_color_plats = p;
            tick();
            if (color_in(b, p)) begin
                found = 1'b1;
                exp_b = b;
                exp_p = p;
            end else if (i == int'(TB_RETRY) - 1) begin
                found = 1'b1;
                exp_b = b;
                exp_p = {p[11:3], b};
            end
            check_eq("arm_colors_valid", 32'(colors_valid), 32'(found));
            check_eq("arm_busy", 32'(busy), 1);
        end
        check_eq("latched_ball", 32'(ball_color), 32'(exp_b));
        check_eq("latched_plats", 32'(plat_colors), 32'(exp_p));
        new_color_ball  = 3'($urandom);
        new_color_plats = 12'($urandom);
        if (to_mode) begin
            for (int i = 0; i < int'(TB_TO) - 1; i++) begin
                tick();
                check_eq("wait_no_miss", 32'(miss), 0);
                check_eq("wait_busy", 32'(busy), 1);
            end
            tick();
            exp_hit = 1'b0;
        end else begin
            for (int i = 0; i < delay; i++) begin
                tick();
                check_eq("wait_no_pulse", 32'({hit, miss}), 0);
            end
            lp = $urandom_range(0, 3);
            if (pos_in >= 0) lp = pos_in;
            else if (pos_in == -2) begin
                for (int k = 3; k >= 0; k--) if (slot_of(exp_p, k) == exp_b) lp = k;
            end else if (pos_in == -3) begin
                for (int k = 3; k >= 0; k--) if (slot_of(exp_p, k) != exp_b) lp = k;
            end
            land_valid = 1'b1;
            land_pos   = 2'(lp);
            tick();
            land_valid = 1'b0;
            land_pos   = 2'($urandom);
            check_eq("judge_no_pulse", 32'({hit, miss}), 0);
            check_eq("judge_busy", 32'(busy), 1);
            tick();
            exp_hit = (slot_of(exp_p, lp) == exp_b);
        end
        if (exp_hit) begin
            if (m_score < int'(TB_SCORE_MAX)) m_score++;
        end else begin
            if (m_lives > 0) m_lives--;
            if (m_lives == 0) m_over = 1'b1;
        end
        check_eq("res_hit", 32'(hit), 32'(exp_hit));
        check_eq("res_miss", 32'(miss), 32'(!exp_hit));
        check_eq("res_score", 32'(score), 32'(m_score));
        check_eq("res_lives", 32'(lives), 32'(m_lives));
        check_eq("res_over", 32'(game_over), 32'(m_over));
        check_eq("res_busy", 32'(busy), 0);
        check_eq("res_colors_valid", 32'(colors_valid), 0);
        check_eq("res_ball_hold", 32'(ball_color), 32'(exp_b));
        tick();
        check_eq("pulse_width", 32'({hit, miss}), 0);
    endtask

    task automatic over_check();
        logic [2:0] held;
        held        = ball_color;
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        land_valid  = 1'b1;
        tick();
        land_valid  = 1'b0;
        tick();
        check_eq("over_busy", 32'(busy), 0);
        check_eq("over_flag", 32'(game_over), 1);
        check_eq("over_lives", 32'(lives), 0);
        check_eq("over_pulse", 32'({hit, miss}), 0);
        check_eq("over_ball_hold", 32'(ball_color), 32'(held));
    endtask

    task automatic reset_mid_wait();
        round_start = 1'b1;
        tick();
        round_start     = 1'b0;
        new_color_ball  = 3'd2;
        new_color_plats = 12'o2222;
        tick();
        check_eq("mid_colors_valid", 32'(colors_valid), 1);
        tick();
        tick();
        resetn     = 1'b0;
        land_valid = 1'b1;
        land_pos   = 2'd0;
        tick();
        resetn     = 1'b1;
        land_valid = 1'b0;
        model_reset();
        check_idle_outputs("mid_rst");
        check_eq("mid_rst_cv", 32'(colors_valid), 0);
        check_eq("mid_rst_ball", 32'(ball_color), 0);
        check_eq("mid_rst_plats", 32'(plat_colors), 0);
        tick();
        check_idle_outputs("mid_rst_after");
    endtask

    initial begin
        int sel;
        do_reset();
        check_idle_outputs("reset");
        check_eq("reset_cv", 32'(colors_valid), 0);
        check_eq("reset_ball", 32'(ball_color), 0);
        check_eq("reset_plats", 32'(plat_colors), 0);

        do_round(5, 12'b000_101_010_001, 1'b0, 1'b0, 3, 2);
        do_round(5, 12'b000_101_010_001, 1'b0, 1'b0, 1, 0);
        do_round(7, 12'h000, 1'b0, 1'b0, 0, 0);

        do_reset();
        for (int r = 0; r < 3; r++) do_round(-1, -1, 1'b0, 1'b1, 0, -1);
        over_check();

        do_reset();
        for (int r = 0; r < 4; r++) do_round(-1, -1, r[0], 1'b0, (r == 3) ? int'(TB_TO) - 1 : r, -2);
        do_round(-1, -1, 1'b1, 1'b0, int'(TB_TO) - 1, -3);

        reset_mid_wait();

        for (int r = 0; r < 80; r++) begin
            if (m_over) begin
                over_check();
                do_reset();
            end
            sel = $urandom_range(1, 3);
            do_round(-1, -1, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, TB_TO - 1), -sel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
